// File: rtl/bcd_pkg.sv
// Shared BCD definitions: FSM state codes, binary width helper and digit validity test.
// Any BCD block in the library can reuse these.
package bcd_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Bits needed to hold any value below 10^n_digits, i.e. ceil(log2(10^n_digits)).
  function automatic int bin_width(input int n_digits);
    longint unsigned limit;
    int width;
    limit = 1;
    for (int i = 0; i < n_digits; i++) limit = limit * 10;
    width = 0;
    for (int b = 0; b < 64; b++) begin
      if ((64'd1 << b) < limit) width = b + 1;
    end
    return width;
  endfunction

  function automatic logic digit_invalid(input logic [3:0] nibble);
    return nibble > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add step of the BCD to binary conversion.
// The product is formed from two shifts in a 4-bit wider field, then truncated.
module bcd_mac10 #(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0] acc_i,
  input  logic [3:0]       digit_i,
  output logic [BIN_W-1:0] acc_o
);

  localparam int EXT_W = BIN_W + 4;

  logic [EXT_W-1:0] acc_ext;

  assign acc_ext = {4'd0, acc_i};
  assign acc_o   = BIN_W'((acc_ext << 3) + (acc_ext << 1) + EXT_W'(digit_i));

endmodule

// File: rtl/bcd_bin_seq.sv
// Sequential packed-BCD to binary converter: one digit per clock, valid/ready on both sides.
// Words containing a nibble above 9 still take the full latency but report out_err with out_bin = 0.
module bcd_bin_seq
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [4*N_DIGITS-1:0]               in_bcd,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [bcd_pkg::bin_width(N_DIGITS)-1:0] out_bin,
  output logic                                out_err
);

  localparam int BIN_W  = bin_width(N_DIGITS);
  localparam int WORD_W = 4 * N_DIGITS;
  localparam int CNT_W  = 4;

  logic [1:0]        state_q, state_d;
  logic [BIN_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] digits_q, digits_d;
  logic              err_q, err_d;
  logic              live_q;
  logic [BIN_W-1:0]  mac_acc;
  logic              word_bad;

  always_comb begin
    word_bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (digit_invalid(in_bcd[4*i +: 4])) word_bad = 1'b1;
    end
  end

  bcd_mac10 #(.BIN_W(BIN_W)) u_mac (
    .acc_i  (acc_q),
    .digit_i(digits_q[WORD_W-1 -: 4]),
    .acc_o  (mac_acc)
  );

  // live_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = (state_q == IDLE) && live_q;
  assign out_valid = (state_q == DONE);
  assign out_err   = out_valid && err_q;
  assign out_bin   = (out_valid && !err_q) ? acc_q : '0;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          digits_d = in_bcd;
          acc_d    = '0;
          cnt_d    = '0;
          err_d    = word_bad;
          state_d  = CONV;
        end
      end
      CONV: begin
        acc_d    = mac_acc;
        digits_d = digits_q << 4;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_DIGITS - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      err_q    <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      err_q    <= err_d;
      live_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_bin_seq.sv
// Self-checking bench for bcd_bin_seq at N_DIGITS = 1, 4 and 9: directed table, corner sequences, random sweep.
module tb_bcd_bin_seq;

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] expBin;
    logic        expErr;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid  [3];
  logic        outReady [3];
  logic [35:0] inBcd    [3];
  wire         inReady  [3];
  wire         outValid [3];
  wire         outErr   [3];
  wire  [29:0] outBin   [3];
  wire  [3:0]  bin1;
  wire  [13:0] bin4;
  wire  [29:0] bin9;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[9];

  assign outBin[0] = {26'd0, bin1};
  assign outBin[1] = {16'd0, bin4};
  assign outBin[2] = bin9;

  always #5 clk = ~clk;

  bcd_bin_seq #(.N_DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]), .in_bcd(inBcd[0][3:0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_bin(bin1), .out_err(outErr[0]));

  bcd_bin_seq #(.N_DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]), .in_bcd(inBcd[1][15:0]),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_bin(bin4), .out_err(outErr[1]));

  bcd_bin_seq #(.N_DIGITS(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReady[2]), .in_bcd(inBcd[2]),
    .out_valid(outValid[2]), .out_ready(outReady[2]), .out_bin(bin9), .out_err(outErr[2]));

  function automatic int digitsOf(input int idx);
    return (idx == 0) ? 1 : (idx == 1) ? 4 : 9;
  endfunction

  // Reference: weigh each decimal digit by its power of ten; any nibble above 9 poisons the word.
  function automatic void refModel(input logic [35:0] w, input int n, output logic [29:0] b, output logic e);
    longint v = 0;
    longint p = 1;
    e = 1'b0;
    for (int d = 0; d < n; d++) begin
      int dig;
      dig = int'(w[4*d +: 4]);
      if (dig > 9) e = 1'b1;
      v += longint'(dig) * p;
      p *= 10;
    end
    b = e ? 30'd0 : 30'(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Offer one word, check exact latency, hold DONE for holdCycles, then hand the result off.
  task automatic applyStimulus(input int idx, input logic [35:0] word, input logic [29:0] expBin,
                               input logic expErr, input int holdCycles, input string name);
    int n;
    int waited;
    n = digitsOf(idx);
    @(negedge clk);
    inValid[idx] = 1'b1;
    inBcd[idx]   = word;
    waited = 0;
    while (inReady[idx] !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({name, ".in_ready_wait"}, 32'(inReady[idx]), 32'd1);
    if (inReady[idx] !== 1'b1) begin
      inValid[idx] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    checkOutput({name, ".busy"}, 32'(inReady[idx]), 32'd0);
    inBcd[idx] = 36'({$urandom(), $urandom()});
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      checkOutput({name, ".valid_lat"}, 32'(outValid[idx]), (c == n) ? 32'd1 : 32'd0);
    end
    inValid[idx] = 1'b0;
    checkOutput({name, ".bin"}, 32'(outBin[idx]), 32'(expBin));
    checkOutput({name, ".err"}, 32'(outErr[idx]), 32'(expErr));
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      outReady[idx] = 1'b0;
      @(posedge clk); #1;
      checkOutput({name, ".hold_valid"}, 32'(outValid[idx]), 32'd1);
      checkOutput({name, ".hold_bin"}, 32'(outBin[idx]), 32'(expBin));
    end
    @(negedge clk);
    outReady[idx] = 1'b1;
    @(posedge clk); #1;
    checkOutput({name, ".released"}, 32'(outValid[idx]), 32'd0);
    @(negedge clk);
    outReady[idx] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [35:0] w;
    logic [29:0] eb;
    logic        ee;
    int          n;

    vecs[0] = '{16'h1234, 14'd1234, 1'b0, "v1234"};
    vecs[1] = '{16'h9999, 14'd9999, 1'b0, "v9999"};
    vecs[2] = '{16'h0000, 14'd0,    1'b0, "v0000"};
    vecs[3] = '{16'h12A4, 14'd0,    1'b1, "v12A4"};
    vecs[4] = '{16'h0042, 14'd42,   1'b0, "v0042"};
    vecs[5] = '{16'hF000, 14'd0,    1'b1, "vF000"};
    vecs[6] = '{16'h0909, 14'd909,  1'b0, "v0909"};
    vecs[7] = '{16'h5001, 14'd5001, 1'b0, "v5001"};
    vecs[8] = '{16'h999A, 14'd0,    1'b1, "v999A"};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inValid[i]  = 1'b0;
      outReady[i] = 1'b0;
      inBcd[i]    = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst%0d.in_ready", i), 32'(inReady[i]), 32'd0);
      checkOutput($sformatf("rst%0d.out_valid", i), 32'(outValid[i]), 32'd0);
      checkOutput($sformatf("rst%0d.out_bin", i), 32'(outBin[i]), 32'd0);
      checkOutput($sformatf("rst%0d.out_err", i), 32'(outErr[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_pre_edge", 32'(inReady[1]), 32'd0);
    @(posedge clk); #1;
    checkOutput("ready_post_edge", 32'(inReady[1]), 32'd1);

    foreach (vecs[i])
      applyStimulus(1, 36'(vecs[i].bcd), 30'(vecs[i].expBin), vecs[i].expErr, i % 3, vecs[i].name);

    // Five stalled cycles in DONE with a competing word offered; it must wait for the post-handshake edge.
    @(negedge clk);
    inValid[1] = 1'b1;
    inBcd[1]   = 36'h1234;
    @(posedge clk); #1;
    inValid[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("stall.valid", 32'(outValid[1]), 32'd1);
    checkOutput("stall.bin", 32'(outBin[1]), 32'd1234);
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      inValid[1] = 1'b1;
      inBcd[1]   = 36'h0777;
      @(posedge clk); #1;
      checkOutput("stall.hold_bin", 32'(outBin[1]), 32'd1234);
      checkOutput("stall.hold_ready", 32'(inReady[1]), 32'd0);
    end
    @(negedge clk);
    outReady[1] = 1'b1;
    @(posedge clk); #1;
    checkOutput("stall.handoff_valid", 32'(outValid[1]), 32'd0);
    checkOutput("stall.handoff_ready", 32'(inReady[1]), 32'd1);
    @(negedge clk);
    outReady[1] = 1'b0;
    @(posedge clk); #1;
    inValid[1] = 1'b0;
    checkOutput("stall.accepted", 32'(inReady[1]), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("stall.next_bin", 32'(outBin[1]), 32'd777);
    @(negedge clk);
    outReady[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    outReady[1] = 1'b0;

    // Reset during the second conversion cycle drops the pending result.
    @(negedge clk);
    inValid[1] = 1'b1;
    inBcd[1]   = 36'h1234;
    @(posedge clk); #1;
    inValid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.out_valid", 32'(outValid[1]), 32'd0);
    checkOutput("midrst.out_bin", 32'(outBin[1]), 32'd0);
    checkOutput("midrst.out_err", 32'(outErr[1]), 32'd0);
    checkOutput("midrst.in_ready", 32'(inReady[1]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      checkOutput("midrst.no_valid", 32'(outValid[1]), 32'd0);
    end
    checkOutput("midrst.ready_back", 32'(inReady[1]), 32'd1);
    applyStimulus(1, 36'h0042, 30'd42, 1'b0, 0, "midrst.next");

    for (int idx = 0; idx < 3; idx++) begin
      n = digitsOf(idx);
      for (int k = 0; k < 30; k++) begin
        w = '0;
        for (int d = 0; d < n; d++) begin
          if ($urandom_range(0, 7) == 0) w[4*d +: 4] = 4'($urandom_range(10, 15));
          else                           w[4*d +: 4] = 4'($urandom_range(0, 9));
        end
        refModel(w, n, eb, ee);
        applyStimulus(idx, w, eb, ee, int'($urandom_range(0, 3)), $sformatf("rnd_n%0d_%0d", n, k));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
